// File: rtl/first_nios2_system_cpu_div_pkg.sv
// Shared types and constants for the Nios II sequential divide cell.
// Optional feature macro used by the cell: FIRST_NIOS2_DIV_ZERO_BYPASS_EN.
package first_nios2_system_cpu_div_pkg;

  localparam int DIV_WIDTH = 32;

  // Replicated to WIDTH bits to form the all-ones divide-by-zero quotient.
  localparam logic DIV0_QUOT_FILL = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/first_nios2_system_cpu_div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the
// divisor magnitude, keep the difference and set the quotient bit when it is non-negative.
module first_nios2_system_cpu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // Two guard bits: one for the shifted-in bit, one for the borrow/sign.
  always_comb begin
    shifted = {1'b0, rem, quo[WIDTH-1]};
    trial   = shifted - {2'b00, divisor};
    if (!trial[WIDTH+1]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/first_nios2_system_cpu_cpu_div_cell.sv
// Sequential radix-2 signed/unsigned divider with valid/ready operand and result ports.
// Optional macro: FIRST_NIOS2_DIV_ZERO_BYPASS_EN (zero divisor goes PREP->DONE directly).
import first_nios2_system_cpu_div_pkg::*;

module first_nios2_system_cpu_cpu_div_cell #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy,
  output div_state_e       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and result outputs hold until taken.

  localparam int CW = $clog2(WIDTH);

  div_state_e       state;
  logic [WIDTH-1:0] dividend_r;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             signed_r;
  logic             q_neg;
  logic             r_neg;
  logic             dz;
  logic [CW-1:0]    cnt;
  logic             divisor_zero;
  logic             dividend_neg;
  logic             divisor_neg;

  assign divisor_zero = (divisor_r == '0);
  assign dividend_neg = signed_r && dividend_r[WIDTH-1];
  assign divisor_neg  = signed_r && divisor_r[WIDTH-1];

  assign start_ready = !reset && ((state == IDLE) || ((state == DONE) && res_ready));
  assign res_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign state_dbg   = state;

  first_nios2_system_cpu_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (divisor_r),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      dividend_r  <= '0;
      divisor_r   <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      signed_r    <= 1'b0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dz          <= 1'b0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            dividend_r <= dividend;
            divisor_r  <= divisor;
            signed_r   <= is_signed;
            state      <= PREP;
          end
        end
        PREP: begin
          // A zero divisor keeps the raw dividend so the remainder comes back unchanged.
          dz        <= divisor_zero;
          q_neg     <= !divisor_zero && (dividend_neg ^ divisor_neg);
          r_neg     <= !divisor_zero && dividend_neg;
          quo_r     <= (!divisor_zero && dividend_neg) ? -dividend_r : dividend_r;
          divisor_r <= divisor_neg ? -divisor_r : divisor_r;
          rem_r     <= '0;
          cnt       <= CW'(WIDTH - 1);
          state     <= ITER;
`ifdef FIRST_NIOS2_DIV_ZERO_BYPASS_EN
          if (divisor_zero) begin
            quotient    <= {WIDTH{DIV0_QUOT_FILL}};
            remainder   <= dividend_r;
            div_by_zero <= 1'b1;
            state       <= DONE;
          end
`endif
        end
        ITER: begin
          rem_r <= rem_nx;
          quo_r <= quo_nx;
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          if (dz) begin
            quotient  <= {WIDTH{DIV0_QUOT_FILL}};
            remainder <= dividend_r;
          end else begin
            quotient  <= q_neg ? -quo_r : quo_r;
            remainder <= r_neg ? -rem_r : rem_r;
          end
          div_by_zero <= dz;
          state       <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            if (start_valid) begin
              dividend_r <= dividend;
              divisor_r  <= divisor;
              signed_r   <= is_signed;
              state      <= PREP;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_first_nios2_system_cpu_cpu_div_cell.sv
// Self-checking bench for the Nios II divide cell against an arithmetic reference model.
// Expected divide-by-zero latency follows FIRST_NIOS2_DIV_ZERO_BYPASS_EN.
import first_nios2_system_cpu_div_pkg::*;

module tb_first_nios2_system_cpu_cpu_div_cell;

  localparam int W = 32;
  localparam int LAT_FULL = W + 3;
`ifdef FIRST_NIOS2_DIV_ZERO_BYPASS_EN
  localparam int LAT_ZERO = 2;
`else
  localparam int LAT_ZERO = W + 3;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;
  div_state_e   state_dbg;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  first_nios2_system_cpu_cpu_div_cell #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // Reference: plain integer division, truncating toward zero for signed operands.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z, output int lat);
    longint sa, sb;
    if (b == '0) begin
      q = '1; r = a; z = 1'b1; lat = LAT_ZERO;
    end else begin
      z = 1'b0; lat = LAT_FULL;
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = W'(sa / sb);
        r = W'(sa % sb);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  task automatic apply_reset();
    reset = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Present operands at a negedge and hold until the accepting posedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n;
    @(negedge clk);
    dividend = a; divisor = b; is_signed = s; start_valid = 1'b1;
    n = 0;
    while (!start_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!start_ready) begin
      total++; bad++;
      $display("FAIL issue_timeout: start_ready=%0b required=1", start_ready);
    end
    @(posedge clk);
    #1 start_valid = 1'b0;
    dividend = $urandom; divisor = $urandom; is_signed = $urandom_range(0, 1);
  endtask

  // Count negedges after the accepting edge until res_valid; leave the result unconsumed.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!res_valid && lat < 200);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s);
    logic [W-1:0] eq, er;
    logic ez;
    int elat, lat;
    model(a, b, s, eq, er, ez, elat);
    issue(a, b, s);
    wait_result(lat);
    total++;
    if (lat !== elat) begin
      bad++;
      $display("FAIL %s_latency: got=%0d required=%0d", name, lat, elat);
    end
    total++;
    if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
      bad++;
      $display("FAIL %s_result: %h/%h s=%0b got q=%h r=%h z=%0b required q=%h r=%h z=%0b",
               name, a, b, s, quotient, remainder, div_by_zero, eq, er, ez);
    end
    consume();
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (start_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 || quotient !== '0 ||
        remainder !== '0 || div_by_zero !== 1'b0 || state_dbg !== IDLE) begin
      bad++;
      $display("FAIL reset_state: rdy=%0b vld=%0b busy=%0b q=%h r=%h z=%0b st=%0d required all 0",
               start_ready, res_valid, busy, quotient, remainder, div_by_zero, state_dbg);
    end
    reset = 1'b0;
    #1;
    total++;
    if (start_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got=%0b required=1", start_ready);
    end
  endtask

  task automatic test_directed();
    check_op("u_100_7", 32'd100, 32'd7, 1'b0);
    total++;
    if (quotient !== 32'd14 || remainder !== 32'd2) begin
      bad++;
      $display("FAIL hold_after_handoff: got q=%0d r=%0d required q=14 r=2", quotient, remainder);
    end
    check_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    check_op("u_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0);
    check_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check_op("u_5_0", 32'd5, 32'd0, 1'b0);
    check_op("s_neg_0", 32'hFFFF_FFF9, 32'd0, 1'b1);
    check_op("s_min_7", 32'h8000_0000, 32'd7, 1'b1);
    check_op("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic s;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = $urandom;
        2: b = W'($urandom_range(1, 300));
        default: b = -W'($urandom_range(1, 300));
      endcase
      s = $urandom_range(0, 1);
      check_op("rand", a, b, s);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] hq, hr;
    logic hz;
    int lat;
    issue(32'd50, 32'd7, 1'b0);
    wait_result(lat);
    hq = quotient; hr = remainder; hz = div_by_zero;
    total++;
    if (hq !== 32'd7 || hr !== 32'd1 || hz !== 1'b0) begin
      bad++;
      $display("FAIL bp_first_result: got q=%0d r=%0d z=%0b required q=7 r=1 z=0", hq, hr, hz);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (res_valid !== 1'b1 || quotient !== hq || remainder !== hr || div_by_zero !== hz ||
          start_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold: cycle=%0d vld=%0b rdy=%0b q=%h r=%h required vld=1 rdy=0 q=%h r=%h",
                 i, res_valid, start_ready, quotient, remainder, hq, hr);
      end
    end
    dividend = 32'd20; divisor = 32'd3; is_signed = 1'b0;
    start_valid = 1'b1; res_ready = 1'b1;
    #1;
    total++;
    if (start_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready: got=%0b required=1", start_ready);
    end
    @(posedge clk);
    #1 start_valid = 1'b0; res_ready = 1'b0;
    wait_result(lat);
    total++;
    if (lat !== LAT_FULL || quotient !== 32'd6 || remainder !== 32'd2) begin
      bad++;
      $display("FAIL b2b_result: got lat=%0d q=%0d r=%0d required lat=%0d q=6 r=2",
               lat, quotient, remainder, LAT_FULL);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(32'd1000, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (state_dbg !== IDLE || busy !== 1'b0 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: st=%0d busy=%0b vld=%0b required st=0 busy=0 vld=0",
               state_dbg, busy, res_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL mid_reset_no_result: got valid cycles=%0d required=0", seen);
    end
    check_op("after_reset_9_3", 32'd9, 32'd3, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    apply_reset();
    check_op("post_reset_u_7_7", 32'd7, 32'd7, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
